// File: rtl/gray_sched_pkg.sv
// Shared constants for the Gray-counter scheduler: state encoding, default
// widths and the 3-bit Gray sequence the shared counter steps through.
package gray_sched_pkg;

   localparam int LEN_W_DEF  = 4;
   localparam int GRAY_W_DEF = 3;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_CLEAR  = 2'd1;
   localparam logic [1:0] ST_COUNT  = 2'd2;
   localparam logic [1:0] ST_FINISH = 2'd3;

   // Entry i sits at bits [3*i +: 3]: 000,001,011,010,110,111,101,100.
   localparam logic [23:0] GRAY_SEQ = {3'b100, 3'b101, 3'b111, 3'b110,
                                       3'b010, 3'b011, 3'b001, 3'b000};

   function automatic logic [1:0] onehot_of(input logic id);
      return id ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/gray_rr_arb.sv
// Two-way round-robin arbiter. Picks a winner combinationally and holds the
// owner from the update strobe until the next one.
module gray_rr_arb
   import gray_sched_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req_i,
   input  logic       ptr_i,
   input  logic       upd_i,
   output logic [1:0] gnt_o,
   output logic       id_o,
   output logic       win_id_o
);

   logic id_q;
   logic win;

   // NOTE: always_comb assigns every output on every path, so no latch can form.
   always_comb begin
      win = 1'b0;
      if (req_i == 2'b11) begin
         win = ptr_i;
      end else if (req_i[1]) begin
         win = 1'b1;
      end
   end

   // NOTE: clocked state uses non-blocking assignments so every flop samples
   // the pre-edge values of its inputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_q <= 1'b0;
      end else if (upd_i && (req_i != 2'b00)) begin
         id_q <= win;
      end
   end

   assign win_id_o = win;
   assign id_o     = id_q;
   assign gnt_o    = onehot_of(id_q);

endmodule

// File: rtl/gray_sched.sv
// Shares one external Gray counter between two requesters: arbitrate, clear the
// counter, enable it for exactly Len cycles, then report the final code and wrap.
module gray_sched
   import gray_sched_pkg::*;
#(
   parameter int LEN_W  = LEN_W_DEF,
   parameter int GRAY_W = GRAY_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_i,
   input  logic [LEN_W-1:0]  len0_i,
   input  logic              req1_i,
   input  logic [LEN_W-1:0]  len1_i,
   output logic [1:0]        gnt_o,
   output logic              done_o,
   output logic              done_id_o,
   output logic [GRAY_W-1:0] result_o,
   output logic              wrapped_o,
   output logic              gray_en_o,
   output logic              gray_clr_o,
   input  logic [GRAY_W-1:0] gray_out_i,
   input  logic              gray_ovf_i
);

   logic [1:0]        state_q, state_d;
   logic [LEN_W-1:0]  rem_q, rem_d;
   logic              sticky_q, sticky_d;
   logic              ptr_q, ptr_d;
   logic              done_q, done_d;
   logic              done_id_q, done_id_d;
   logic [GRAY_W-1:0] result_q, result_d;
   logic              wrapped_q, wrapped_d;

   logic [1:0] req;
   logic [1:0] arb_gnt;
   logic       owner;
   logic       win_id;
   logic       arb_upd;

   assign req     = {req1_i, req0_i};
   assign arb_upd = (state_q == ST_IDLE);

   gray_rr_arb u_arb (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_i    (req),
      .ptr_i    (ptr_q),
      .upd_i    (arb_upd),
      .gnt_o    (arb_gnt),
      .id_o     (owner),
      .win_id_o (win_id)
   );

   always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      sticky_d  = sticky_q;
      ptr_d     = ptr_q;
      done_d    = 1'b0;
      done_id_d = done_id_q;
      result_d  = result_q;
      wrapped_d = wrapped_q;

      case (state_q)
         ST_IDLE: begin
            if (req != 2'b00) begin
               state_d  = ST_CLEAR;
               rem_d    = win_id ? len1_i : len0_i;
               sticky_d = 1'b0;
            end
         end
         ST_CLEAR: begin
            state_d = (rem_q != '0) ? ST_COUNT : ST_FINISH;
         end
         ST_COUNT: begin
            rem_d    = rem_q - LEN_W'(1);
            sticky_d = sticky_q | gray_ovf_i;
            if (rem_q == LEN_W'(1)) begin
               state_d = ST_FINISH;
            end
         end
         ST_FINISH: begin
            // An overflow landing on the final enabled cycle is only visible now.
            sticky_d  = sticky_q | gray_ovf_i;
            result_d  = gray_out_i;
            done_id_d = owner;
            wrapped_d = sticky_q | gray_ovf_i;
            done_d    = 1'b1;
            ptr_d     = ~owner;
            state_d   = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         rem_q     <= '0;
         sticky_q  <= 1'b0;
         ptr_q     <= 1'b0;
         done_q    <= 1'b0;
         done_id_q <= 1'b0;
         result_q  <= '0;
         wrapped_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rem_q     <= rem_d;
         sticky_q  <= sticky_d;
         ptr_q     <= ptr_d;
         done_q    <= done_d;
         done_id_q <= done_id_d;
         result_q  <= result_d;
         wrapped_q <= wrapped_d;
      end
   end

   assign gnt_o      = (state_q != ST_IDLE) ? arb_gnt : 2'b00;
   assign gray_en_o  = (state_q == ST_COUNT);
   assign gray_clr_o = (state_q == ST_CLEAR);
   assign done_o     = done_q;
   assign done_id_o  = done_id_q;
   assign result_o   = result_q;
   assign wrapped_o  = wrapped_q;

endmodule
